// File: rtl/axim_ctrl_multi_counter_if.sv
// rtl/axim_ctrl_multi_counter_if.sv - strobe/amount/flag bundle for the multi-channel counter bank
interface axim_ctrl_multi_counter_if #(
    parameter int C_CHANNELS   = 4,
    parameter int C_WIDTH      = 8,
    parameter int C_STEP_WIDTH = 4
);
    logic                               clken;
    logic [C_CHANNELS-1:0]              load;
    logic [C_CHANNELS*C_WIDTH-1:0]      load_value;
    logic [C_CHANNELS-1:0]              incr;
    logic [C_CHANNELS*C_STEP_WIDTH-1:0] incr_amt;
    logic [C_CHANNELS-1:0]              decr;
    logic [C_CHANNELS*C_STEP_WIDTH-1:0] decr_amt;
    logic [C_CHANNELS-1:0]              err_clr;
    logic [C_CHANNELS*C_WIDTH-1:0]      count;
    logic [C_CHANNELS-1:0]              is_zero;
    logic [C_CHANNELS-1:0]              at_thresh;
    logic [C_CHANNELS-1:0]              ovf;
    logic [C_CHANNELS-1:0]              unf;

    modport master (
        output clken, load, load_value, incr, incr_amt, decr, decr_amt, err_clr,
        input  count, is_zero, at_thresh, ovf, unf
    );

    modport slave (
        input  clken, load, load_value, incr, incr_amt, decr, decr_amt, err_clr,
        output count, is_zero, at_thresh, ovf, unf
    );
endinterface

// File: rtl/axim_ctrl_multi_counter.sv
// rtl/axim_ctrl_multi_counter.sv - per-channel variable-step up/down counters with zero/threshold/sticky error flags
// Optional build macro AXIM_CTRL_MULTI_COUNTER_SATURATE_EN: clamp on overflow/underflow instead of wrapping.
module axim_ctrl_multi_counter #(
    parameter int                 C_CHANNELS   = 4,
    parameter int                 C_WIDTH      = 8,
    parameter int                 C_STEP_WIDTH = 4,
    parameter logic [C_WIDTH-1:0] C_INIT       = '0,
    parameter int                 C_THRESH     = 2**(C_WIDTH-1)
) (
    input  logic                        clk,
    input  logic                        rst,
    axim_ctrl_multi_counter_if.slave    bus
);
    localparam int W = C_WIDTH;
    localparam int S = C_STEP_WIDTH;
    localparam int N = C_CHANNELS;
    localparam logic [W-1:0] MAX_VAL = '1;
    localparam logic INIT_ZERO = (C_INIT == '0);
    localparam logic INIT_THR  = ({{(33-W){1'b0}}, C_INIT} >= 33'(C_THRESH));

    logic [N*W-1:0] count_q,     count_nxt;
    logic [N-1:0]   is_zero_q,   is_zero_nxt;
    logic [N-1:0]   at_thresh_q, at_thresh_nxt;
    logic [N-1:0]   ovf_q,       ovf_nxt;
    logic [N-1:0]   unf_q,       unf_nxt;

    always_comb begin
        logic [W-1:0]          cur;
        logic [W-1:0]          nxt;
        logic [S-1:0]          inc_amt;
        logic [S-1:0]          dec_amt;
        logic signed [W+1:0]   net;
        logic                  over;
        logic                  under;
        count_nxt     = count_q;
        is_zero_nxt   = is_zero_q;
        at_thresh_nxt = at_thresh_q;
        ovf_nxt       = ovf_q;
        unf_nxt       = unf_q;
        cur     = '0;
        nxt     = '0;
        inc_amt = '0;
        dec_amt = '0;
        net     = '0;
        over    = 1'b0;
        under   = 1'b0;
        for (int i = 0; i < N; i++) begin
            cur     = count_q[i*W +: W];
            inc_amt = bus.incr[i] ? bus.incr_amt[i*S +: S] : '0;
            dec_amt = bus.decr[i] ? bus.decr_amt[i*S +: S] : '0;
            // Two guard bits: the top one is the sign, the next one flags a carry past MAX_VAL.
            net   = $signed({2'b00, cur})
                  + $signed({{(W+2-S){1'b0}}, inc_amt})
                  - $signed({{(W+2-S){1'b0}}, dec_amt});
            over  = !net[W+1] && net[W];
            under = net[W+1];
            if (bus.load[i]) begin
                nxt   = bus.load_value[i*W +: W];
                over  = 1'b0;
                under = 1'b0;
            end else if (over) begin
`ifdef AXIM_CTRL_MULTI_COUNTER_SATURATE_EN
                nxt = MAX_VAL;
`else
                nxt = net[W-1:0];
`endif
            end else if (under) begin
`ifdef AXIM_CTRL_MULTI_COUNTER_SATURATE_EN
                nxt = '0;
`else
                nxt = net[W-1:0];
`endif
            end else begin
                nxt = net[W-1:0];
            end
            count_nxt[i*W +: W] = nxt;
            is_zero_nxt[i]      = (nxt == '0);
            at_thresh_nxt[i]    = ({{(33-W){1'b0}}, nxt} >= 33'(C_THRESH));
            // A fresh event outranks a same-cycle clear.
            ovf_nxt[i] = (ovf_q[i] && !bus.err_clr[i]) || over;
            unf_nxt[i] = (unf_q[i] && !bus.err_clr[i]) || under;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q     <= {N{C_INIT}};
            is_zero_q   <= {N{INIT_ZERO}};
            at_thresh_q <= {N{INIT_THR}};
            ovf_q       <= '0;
            unf_q       <= '0;
        end else if (bus.clken) begin
            count_q     <= count_nxt;
            is_zero_q   <= is_zero_nxt;
            at_thresh_q <= at_thresh_nxt;
            ovf_q       <= ovf_nxt;
            unf_q       <= unf_nxt;
        end
    end

    assign bus.count     = count_q;
    assign bus.is_zero   = is_zero_q;
    assign bus.at_thresh = at_thresh_q;
    assign bus.ovf       = ovf_q;
    assign bus.unf       = unf_q;
endmodule

// File: tb/tb_axim_ctrl_multi_counter.sv
// tb/tb_axim_ctrl_multi_counter.sv - directed self-checking bench for axim_ctrl_multi_counter
module tb_axim_ctrl_multi_counter;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    axim_ctrl_multi_counter_if #(.C_CHANNELS(4), .C_WIDTH(8), .C_STEP_WIDTH(4)) bus ();

    axim_ctrl_multi_counter #(
        .C_CHANNELS(4), .C_WIDTH(8), .C_STEP_WIDTH(4), .C_INIT(8'd0), .C_THRESH(128)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.clken      = 1'b1;
        bus.load       = '0;
        bus.load_value = '0;
        bus.incr       = '0;
        bus.incr_amt   = '0;
        bus.decr       = '0;
        bus.decr_amt   = '0;
        bus.err_clr    = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic do_load(input int ch, input logic [7:0] v);
        bus.load[ch]             = 1'b1;
        bus.load_value[ch*8 +: 8] = v;
    endtask

    task automatic do_incr(input int ch, input logic [3:0] a);
        bus.incr[ch]            = 1'b1;
        bus.incr_amt[ch*4 +: 4] = a;
    endtask

    task automatic do_decr(input int ch, input logic [3:0] a);
        bus.decr[ch]            = 1'b1;
        bus.decr_amt[ch*4 +: 4] = a;
    endtask

    function automatic logic [7:0] cnt(input int ch);
        return bus.count[ch*8 +: 8];
    endfunction

    initial begin
        checks   = 0;
        failures = 0;
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_count",  bus.count,     32'h0);
        check("rst_zero",   bus.is_zero,   32'hf);
        check("rst_thresh", bus.at_thresh, 32'h0);
        check("rst_ovf",    bus.ovf,       32'h0);
        check("rst_unf",    bus.unf,       32'h0);

        rst = 1'b0;
        do_load(0, 8'd36);
        step();
        do_incr(0, 4'd1);
        step();
        check("mid_count", cnt(0), 32'd37);
        check("mid_zero",  bus.is_zero, 32'he);
        #2 rst = 1'b1;
        #1;
        check("async_rst_count", bus.count,   32'h0);
        check("async_rst_zero",  bus.is_zero, 32'hf);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        do_load(0, 8'd5);
        step();
        do_incr(0, 4'd3); do_decr(0, 4'd3);
        step();
        check("ch0_eq_count", cnt(0), 32'd5);
        check("ch0_eq_flags", {bus.ovf[0], bus.unf[0]}, 32'd0);
        do_incr(0, 4'd3); do_decr(0, 4'd1);
        step();
        check("ch0_net2", cnt(0), 32'd7);

        do_load(0, 8'd255);
        step();
        do_incr(0, 4'd4); do_decr(0, 4'd4);
        step();
        check("ch0_eq_max", cnt(0), 32'd255);
        check("ch0_eq_max_ovf", bus.ovf[0], 32'd0);
        do_load(0, 8'd0);
        step();
        do_incr(0, 4'd2); do_decr(0, 4'd2);
        step();
        check("ch0_eq_zero", {bus.unf[0], bus.is_zero[0]}, 32'd1);

        do_load(1, 8'd250);
        step();
        do_incr(1, 4'd9);
        step();
`ifdef AXIM_CTRL_MULTI_COUNTER_SATURATE_EN
        check("ch1_ovf_count", cnt(1), 32'd255);
`else
        check("ch1_ovf_count", cnt(1), 32'd3);
`endif
        check("ch1_ovf", bus.ovf[1], 32'd1);
        do_load(1, 8'd250);
        step();
        check("ch1_ovf_sticky", bus.ovf[1], 32'd1);
        do_incr(1, 4'd9);
        bus.err_clr[1] = 1'b1;
        step();
        check("ch1_clr_vs_event", bus.ovf[1], 32'd1);
        bus.err_clr[1] = 1'b1;
        step();
        check("ch1_clr", bus.ovf[1], 32'd0);

        do_load(2, 8'd2);
        step();
        do_decr(2, 4'd5);
        step();
`ifdef AXIM_CTRL_MULTI_COUNTER_SATURATE_EN
        check("ch2_unf_count", cnt(2), 32'd0);
        check("ch2_unf_zero",  bus.is_zero[2], 32'd1);
`else
        check("ch2_unf_count", cnt(2), 32'd253);
        check("ch2_unf_zero",  bus.is_zero[2], 32'd0);
`endif
        check("ch2_unf", bus.unf[2], 32'd1);

        do_load(3, 8'd128); do_incr(3, 4'd15);
        step();
        check("ch3_load_count", cnt(3), 32'd128);
        check("ch3_load_thr",   bus.at_thresh[3], 32'd1);
        check("ch3_load_ovf",   bus.ovf[3], 32'd0);
        do_decr(3, 4'd1);
        step();
        check("ch3_dec_count", cnt(3), 32'd127);
        check("ch3_dec_thr",   bus.at_thresh[3], 32'd0);

        do_load(0, 8'd10); do_load(1, 8'd20); do_load(2, 8'd30); do_load(3, 8'd40);
        step();
        check("pre_hold_count", bus.count, 32'h281e140a);
        for (int k = 0; k < 3; k++) begin
            bus.clken   = 1'b0;
            bus.load    = 4'b0001;
            bus.load_value = 32'h63636363;
            bus.incr    = 4'hf;
            bus.incr_amt = 16'hffff;
            bus.decr    = 4'he;
            bus.decr_amt = 16'h1111;
            bus.err_clr = 4'hf;
            step();
            check("hold_count", bus.count,     32'h281e140a);
            check("hold_unf",   bus.unf,       32'h4);
            check("hold_zero",  bus.is_zero,   32'h0);
            check("hold_thr",   bus.at_thresh, 32'h0);
        end

        do_incr(0, 4'd5);
        do_decr(1, 4'd7);
        do_load(2, 8'd200);
        do_incr(3, 4'd6); do_decr(3, 4'd2);
        step();
        check("multi_count", bus.count,     32'h2cc80d0f);
        check("multi_thr",   bus.at_thresh, 32'h4);
        check("multi_zero",  bus.is_zero,   32'h0);
        check("multi_ovf",   bus.ovf,       32'h0);
        check("multi_unf",   bus.unf,       32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/axim_ctrl_multi_counter.md
# axim_ctrl_multi_counter

Multi-channel, variable-step up/down counter bank for the AXI master control path. It tracks outstanding beats, bursts or credits for several channels at once. Each channel supports a load, a simultaneous increment and decrement by arbitrary step amounts, configurable overflow handling, and registered zero, threshold and sticky-error flags. Sits between the AXI master command/response FSMs and the issue logic that throttles new requests.

## Interface
Parameters:
- C_CHANNELS, 4, number of independent counters
- C_WIDTH, 8, bits per counter
- C_STEP_WIDTH, 4, bits of each increment/decrement amount
- C_INIT, 0, reset/initial value of every counter (C_WIDTH bits)
- C_THRESH, 2**(C_WIDTH-1), per-channel threshold compared against count

Ports (channel i occupies slice [i*W +: W] of packed buses):
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- clken  in  1  global clock enable; low holds all state
- load  in  C_CHANNELS  per-channel load strobe
- load_value  in  C_CHANNELS*C_WIDTH  value written on load
- incr  in  C_CHANNELS  per-channel increment strobe
- incr_amt  in  C_CHANNELS*C_STEP_WIDTH  increment amount (0 legal)
- decr  in  C_CHANNELS  per-channel decrement strobe
- decr_amt  in  C_CHANNELS*C_STEP_WIDTH  decrement amount (0 legal)
- err_clr  in  C_CHANNELS  clears sticky error flags
- count  out  C_CHANNELS*C_WIDTH  registered counter values
- is_zero  out  C_CHANNELS  registered, count == 0
- at_thresh  out  C_CHANNELS  registered, count >= C_THRESH
- ovf  out  C_CHANNELS  sticky overflow flag
- unf  out  C_CHANNELS  sticky underflow flag

## Operation
- Channels are fully independent. No cross-channel interaction.
- Per channel, when clken is high, the priority is:
  - load: count <= load_value. Flags are recomputed from load_value. ovf/unf are not set. incr/decr are ignored.
  - Otherwise: eff_inc = incr ? incr_amt : 0, and eff_dec = decr ? decr_amt : 0.
  - net = count + eff_inc - eff_dec, computed signed at C_WIDTH+2 bits with no intermediate truncation.
- 0 <= net <= 2**C_WIDTH-1: count <= net.
- net > max: overflow event. ovf <= 1. count is handled per Configuration.
- net < 0: underflow event. unf <= 1. count is handled per Configuration.
- incr and decr with equal amounts in the same cycle: count is unchanged and no event occurs, even when count is at 0 or at max.
- is_zero and at_thresh are registered. They are derived from the next count value, so they change in the same cycle as count, not one cycle later.
- err_clr[i] clears ovf[i] and unf[i]. An event in the same cycle wins: the flag stays set.
- clken low: count, is_zero, at_thresh, ovf and unf all hold. Strobes and err_clr are ignored.

## Timing
- Reset (asynchronous, takes effect immediately, no clock needed):
  - count = C_INIT
  - is_zero = (C_INIT == 0)
  - at_thresh = (C_INIT >= C_THRESH)
  - ovf = 0, unf = 0
- Reset deassertion mid-operation: the first update occurs on the first rising edge with rst low and clken high.
- Latency: inputs sampled at edge N are visible on all outputs after edge N. There is one cycle of latency and no combinational input-to-output paths.
- Back-to-back strobes every cycle are supported at full throughput.

## Configuration
- AXIM_CTRL_MULTI_COUNTER_SATURATE_EN:
  - Defined: overflow clamps count to 2**C_WIDTH-1, and underflow clamps count to 0.
  - Undefined: count <= net mod 2**C_WIDTH (wrap-around).
  - ovf/unf flag behaviour is identical in both builds.

## Test plan
- Reset with C_INIT=0, C_THRESH=128 → all count=0, is_zero=1, at_thresh=0, ovf=unf=0. Assert rst asynchronously mid-count (count=37) → outputs return to the reset values before the next edge.
- Ch0 count=5, incr amt 3 and decr amt 3 in the same cycle → count=5, no flags. Then incr 3 / decr 1 → count=7.
- Ch1 count=250, incr amt 9:
  - SATURATE_EN defined → count=255, ovf=1.
  - Undefined → count=3, ovf=1.
  - err_clr plus a new overflow in the same cycle → ovf stays 1. err_clr alone → ovf=0.
- Ch2 count=2, decr amt 5:
  - SATURATE_EN defined → count=0, is_zero=1, unf=1.
  - Undefined → count=253, is_zero=0, unf=1.
- Ch3 load=1 with load_value=128 while incr amt 15 → count=128, at_thresh=1, no ovf. Next cycle decr 1 → count=127, at_thresh=0 on the same edge.
- clken=0 for 3 cycles with strobes active on all channels → no output changes. With all four channels active simultaneously with different ops → each result is independent.
